// File: rtl/div_disp_pkg.sv
// rtl/div_disp_pkg.sv - shared constants, state encoding and glyph lookup for div_result_display
package div_disp_pkg;

    // Number of display digits, and the width of the BCD word that feeds them
    localparam int BCD_DIGITS = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_R     = 7'h2F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Decimal digit to segment pattern; non-decimal codes show nothing
    function automatic logic [6:0] seg_digit(input logic [3:0] d);
        case (d)
            4'd0:    seg_digit = SEG_0;
            4'd1:    seg_digit = SEG_1;
            4'd2:    seg_digit = SEG_2;
            4'd3:    seg_digit = SEG_3;
            4'd4:    seg_digit = SEG_4;
            4'd5:    seg_digit = SEG_5;
            4'd6:    seg_digit = SEG_6;
            4'd7:    seg_digit = SEG_7;
            4'd8:    seg_digit = SEG_8;
            4'd9:    seg_digit = SEG_9;
            default: seg_digit = SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/div_result_display_bin2bcd_seq.sv
// rtl/div_result_display_bin2bcd_seq.sv - iterative double-dabble binary to BCD engine
module bin2bcd_seq
    import div_disp_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] bin,
    output logic [15:0]      bcd,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] shift_q;
    logic [15:0]      work_q;
    logic [CNT_W-1:0] cnt_q;
    logic [15:0]      adj;

    // Add 3 to every nibble that is 5 or more before it is doubled by the shift
    always_comb begin
        adj = work_q;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (work_q[i*4 +: 4] >= 4'd5) begin
                adj[i*4 +: 4] = work_q[i*4 +: 4] + 4'd3;
            end
        end
    end

    // A start reloads the engine at any time, so a newer request always wins
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_q <= '0;
            work_q  <= '0;
            cnt_q   <= '0;
            done    <= 1'b0;
        end else if (start) begin
            shift_q <= bin;
            work_q  <= '0;
            cnt_q   <= CNT_W'(WIDTH);
            done    <= 1'b0;
        end else if (cnt_q != '0) begin
            work_q  <= {adj[14:0], shift_q[WIDTH-1]};
            shift_q <= {shift_q[WIDTH-2:0], 1'b0};
            cnt_q   <= cnt_q - CNT_W'(1);
            done    <= (cnt_q == CNT_W'(1));
        end else begin
            done    <= 1'b0;
        end
    end

    assign bcd = work_q;

endmodule

// File: rtl/div_result_display.sv
// rtl/div_result_display.sv - result capture, BCD conversion sequencing and 4-digit scan (option: LEADING_ZERO_BLANK_EN)
module div_result_display
    import div_disp_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int REFRESH_CNT = 50000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ready,
    input  logic             error,
    input  logic [WIDTH-1:0] quotient,
    input  logic [WIDTH-1:0] remainder,
    input  logic             show_rem,
    output logic             busy,
    output logic [6:0]       seg,
    output logic [3:0]       an,
    output logic             dp
);

    localparam int SCAN_W = (REFRESH_CNT > 1) ? $clog2(REFRESH_CNT) : 1;
    localparam int IDX_W  = $clog2(BCD_DIGITS);

    state_t           state;
    logic [WIDTH-1:0] quo_lat;
    logic [WIDTH-1:0] rem_lat;
    logic             err_flag;
    logic             have_result;
    logic             show_rem_q;
    logic [15:0]      disp_bcd;
    logic [SCAN_W-1:0] scan_cnt;
    logic [IDX_W-1:0] digit_idx;

    logic             cap;
    logic             err_cap;
    logic             rem_edge;
    logic             start_conv;
    logic [WIDTH-1:0] conv_bin;
    logic             copy_disp;
    logic             err_nxt;
    logic             have_nxt;
    logic [15:0]      disp_nxt;
    logic [IDX_W-1:0] idx_nxt;
    logic [SCAN_W-1:0] scan_nxt;
    logic [6:0]       seg_nxt;
    logic [3:0]       nib;
    logic [15:0]      eng_bcd;
    logic             eng_done;

    bin2bcd_seq #(
        .WIDTH (WIDTH)
    ) u_bin2bcd (
        .clk   (clk),
        .reset (reset),
        .start (start_conv),
        .bin   (conv_bin),
        .bcd   (eng_bcd),
        .done  (eng_done)
    );

    // Trigger decode: ready wins over a show_rem edge; an error never converts
    always_comb begin
        cap        = ready & ~error;
        err_cap    = ready & error;
        rem_edge   = (show_rem != show_rem_q) & have_result & ~err_flag;
        start_conv = cap | (~ready & rem_edge);
        if (cap) begin
            conv_bin = show_rem ? remainder : quotient;
        end else begin
            conv_bin = show_rem ? rem_lat : quo_lat;
        end
        copy_disp = (state == ST_DONE) & ~start_conv & ~err_cap;
        err_nxt   = err_cap ? 1'b1 : (cap ? 1'b0 : err_flag);
        have_nxt  = have_result | err_cap | copy_disp;
        disp_nxt  = copy_disp ? eng_bcd : disp_bcd;
    end

    // Capture and conversion sequencing; busy covers CONVERT and DONE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            busy        <= 1'b0;
            quo_lat     <= '0;
            rem_lat     <= '0;
            err_flag    <= 1'b0;
            have_result <= 1'b0;
            show_rem_q  <= 1'b0;
            disp_bcd    <= '0;
        end else begin
            show_rem_q  <= show_rem;
            err_flag    <= err_nxt;
            have_result <= have_nxt;
            disp_bcd    <= disp_nxt;
            if (cap) begin
                quo_lat <= quotient;
                rem_lat <= remainder;
            end
            if (err_cap) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
            end else if (start_conv) begin
                state <= ST_CONVERT;
                busy  <= 1'b1;
            end else begin
                case (state)
                    ST_CONVERT: begin
                        if (eng_done) begin
                            state <= ST_DONE;
                        end
                    end
                    ST_DONE: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Free-running digit scan: advance the digit each time the refresh count wraps
    always_comb begin
        if (scan_cnt == SCAN_W'(REFRESH_CNT - 1)) begin
            scan_nxt = '0;
            idx_nxt  = digit_idx + IDX_W'(1);
        end else begin
            scan_nxt = scan_cnt + SCAN_W'(1);
            idx_nxt  = digit_idx;
        end
    end

    // Segment decode from next-cycle values so seg, an and new results move together
    always_comb begin
        nib     = disp_nxt[{idx_nxt, 2'b00} +: 4];
        seg_nxt = SEG_BLANK;
        if (!have_nxt) begin
            seg_nxt = SEG_BLANK;
        end else if (err_nxt) begin
            case (idx_nxt)
                2'd3:    seg_nxt = SEG_E;
                2'd2:    seg_nxt = SEG_R;
                2'd1:    seg_nxt = SEG_R;
                default: seg_nxt = SEG_BLANK;
            endcase
        end else begin
            seg_nxt = seg_digit(nib);
`ifdef LEADING_ZERO_BLANK_EN
            case (idx_nxt)
                2'd1:    if (disp_nxt[15:4]  == '0) seg_nxt = SEG_BLANK;
                2'd2:    if (disp_nxt[15:8]  == '0) seg_nxt = SEG_BLANK;
                2'd3:    if (disp_nxt[15:12] == '0) seg_nxt = SEG_BLANK;
                default: ;
            endcase
`endif
        end
    end

    // Scan state and registered display drive
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scan_cnt  <= '0;
            digit_idx <= '0;
            seg       <= SEG_BLANK;
            an        <= 4'hF;
        end else begin
            scan_cnt  <= scan_nxt;
            digit_idx <= idx_nxt;
            seg       <= seg_nxt;
            an        <= have_nxt ? ~(4'b0001 << idx_nxt) : 4'hF;
        end
    end

    assign dp = 1'b1;

endmodule

// File: doc/div_result_display.md
Name: div_result_display

Overview:
- Downstream stage of the divider control FSM and datapath.
- Captures quotient/remainder on the FSM's one-cycle `ready` status. When `error` accompanies it, captures an error flag instead.
- Converts the selected value to BCD with an iterative double-dabble (shift-add-3) engine.
- Drives a 4-digit multiplexed, active-low seven-segment display, which is the calculator's only result output.

Parameters:
- WIDTH, 8, bit width of quotient and remainder; legal range 4..13 (result ≤ 9999).
- REFRESH_CNT, 50000, clk cycles each digit is enabled before the scan advances; minimum 2.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-high reset
- ready  input  1  one-cycle pulse from divider FSM: result (or error) valid this cycle
- error  input  1  qualifies ready: division by zero
- quotient  input  WIDTH  divider quotient, sampled when ready=1
- remainder  input  WIDTH  divider remainder, sampled when ready=1
- show_rem  input  1  level: 0 = display quotient, 1 = display remainder
- busy  output  1  high while BCD conversion runs
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low
- an  output  4  digit enables, active-low, an[0] = least-significant digit
- dp  output  1  decimal point, active-low; held 1 (off)

Behaviour:
- Reset (async): state IDLE, busy=0, seg=7'h7F, an=4'hF, dp=1, captured values=0, err_flag=0, have_result=0, scan counter=0, digit index=0, displayed BCD=0.
- Capture on a ready=1 cycle:
  - error=1: err_flag←1, have_result←1, no conversion, state IDLE.
  - error=0: latch quotient and remainder, err_flag←0, start conversion of the value selected by the current show_rem.
- A show_rem edge (compared with a registered copy) while have_result=1 and err_flag=0 restarts conversion from the latched values.
- FSM states:
  - IDLE → CONVERT on trigger.
  - CONVERT runs WIDTH shift cycles, then → DONE.
  - DONE lasts 1 cycle, copies the working BCD to the display BCD, sets have_result←1, then → IDLE.
- Latency: ready to display update is WIDTH+2 cycles; busy=1 in CONVERT and DONE.
- During CONVERT, the display keeps the previous display BCD (no partial digits shown).
- ready during CONVERT/DONE aborts the current conversion and restarts with the new values; the latest ready always wins.
- ready with error=1 during CONVERT: abort, busy←0, Err shown next cycle.
- ready has priority over a simultaneous show_rem edge.
- Double-dabble: 16-bit BCD working register plus WIDTH-bit shift register. Each cycle, add 3 to every BCD nibble ≥5, then shift left 1.
- Scan counter counts 0..REFRESH_CNT-1. On wrap, digit index increments 0→1→2→3→0.
- Output encoding:
  - an = ~(1<<digit index) once have_result=1; 4'hF before that.
  - seg is registered, so it changes with an on the same edge.
  - err_flag=1: digits 3..0 show "E","r","r",blank.
- The scan runs continuously from reset, independent of conversion.

Optional Feature:
- LEADING_ZERO_BLANK_EN defined: leading zero digits above digit 0 are blanked (seg=7'h7F); value 0 shows a single "0". Err display is unaffected.
- Not defined: all four digits always shown, including leading zeros.

Decomposition:
- Package div_disp_pkg holds:
  - the seven-segment constants for 0-9, E, r and blank;
  - the state encodings IDLE/CONVERT/DONE;
  - the BCD digit count constant (4).
- One sub-module, bin2bcd_seq: the iterative double-dabble engine with inputs start, bin[WIDTH] and outputs bcd[15:0], done.
- The top level holds capture, FSM sequencing, scan counter and segment decode.

Test Plan (REFRESH_CNT=4):
- quotient=123, ready pulse → busy high for 10 cycles; digits 3..0 = 0,1,2,3; an steps E,D,B,7 every 4 cycles, repeating.
- ready with error=1 → within 1 cycle, digits 3..0 show E,r,r,blank; busy stays 0.
- quotient=45, remainder=7, then show_rem 0→1 after display → reconversion; display 0007, then back to 0045 on return to 0.
- ready quotient=200, second ready quotient=17 three cycles later → final display 0017; 200 is never displayed.
- reset asserted mid-CONVERT → immediately an=F, seg=7F, busy=0; next ready with quotient=255 → display 0255.
- LEADING_ZERO_BLANK_EN: quotient=9 → digits 3..1 blank, digit 0 shows "9"; quotient=0 → single "0".
